// File: rtl/fifo_pkg.sv
// Shared definitions for the width-converting FIFOs (upsizing and downsizing).
//   DEFAULT_DATA_WIDTH : default byte width on the narrow side
//   DEFAULT_ADDR_WIDTH : default log2 of the word depth
//   BYTE_ORDER         : placement of the earlier byte inside a wide word
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   typedef enum logic {
      BYTE_ORDER_LITTLE = 1'b0,  // earlier byte in the low half
      BYTE_ORDER_BIG    = 1'b1   // earlier byte in the high half
   } byte_order_t;

   localparam byte_order_t BYTE_ORDER = BYTE_ORDER_LITTLE;

   // True when a byte that opens a word (even byte address) belongs in the low lane.
   function automatic logic first_byte_low(input byte_order_t order);
      return (order == BYTE_ORDER_LITTLE);
   endfunction

endpackage

// File: rtl/fifo_upsize_ctrl.sv
// Pointer, count and flag control for the byte-in / word-out FIFO.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr, rd     : write (one byte) and read (one word = two bytes) requests
//   wr_ok      : write accepted this cycle (drives storage lane enables)
//   wr_ptr     : byte pointer, ADDR_WIDTH+1 bits
//   rd_ptr     : word pointer, ADDR_WIDTH bits
//   count      : stored byte count, 0 .. 2**(ADDR_WIDTH+1)
//   full       : count at byte capacity
//   empty      : fewer than two bytes stored (no complete word)
// Handshake: a write is taken when wr=1 and the FIFO is not full, or when a
// read is taken in the same cycle; a read is taken when rd=1 and empty=0.
// Requests that are not taken leave all state untouched.
module fifo_upsize_ctrl #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   output logic                  wr_ok,
   output logic [ADDR_WIDTH:0]   wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_ptr,
   output logic [ADDR_WIDTH+1:0] count,
   output logic                  full,
   output logic                  empty
);

   localparam logic [ADDR_WIDTH+1:0] BYTE_DEPTH = (ADDR_WIDTH+2)'(2 ** (ADDR_WIDTH + 1));
   localparam logic [ADDR_WIDTH+1:0] CNT_ONE    = (ADDR_WIDTH+2)'(1);
   localparam logic [ADDR_WIDTH+1:0] CNT_TWO    = (ADDR_WIDTH+2)'(2);
   localparam logic [ADDR_WIDTH:0]   WP_ONE     = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] RP_ONE     = ADDR_WIDTH'(1);

   logic rd_ok;

   // Flags come from the count register only, so they never see wr/rd.
   assign full  = (count == BYTE_DEPTH);
   assign empty = (count < CNT_TWO);

   assign rd_ok = rd & ~empty;
   // When full, a simultaneous read frees the slot the write lands in.
   assign wr_ok = wr & (~full | rd_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + WP_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + RP_ONE;
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_TWO;
            2'b11:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_upsize.sv
// Upsizing FIFO: accepts one DATA_WIDTH byte per write, returns one
// 2*DATA_WIDTH word per read, first-word-fall-through.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wr, w_data : byte write request and data
//   rd         : word read request
//   r_data     : oldest complete word (undefined while empty=1)
//   full       : byte count equals 2**(ADDR_WIDTH+1)
//   empty      : no complete word stored
//   count      : stored byte count
// Storage is two byte lanes indexed by word address; the byte pointer's LSB
// picks the lane, so a word becomes readable once its second byte lands.
module fifo_upsize
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    rd,
   output logic [2*DATA_WIDTH-1:0] r_data,
   output logic                    full,
   output logic                    empty,
   output logic [ADDR_WIDTH+1:0]   count
);

   localparam int WORDS = 2 ** ADDR_WIDTH;

   logic                  wr_ok;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_word;
   logic                  opens_word;
   logic                  lo_we;
   logic                  hi_we;

   logic [DATA_WIDTH-1:0] lane_lo [WORDS];
   logic [DATA_WIDTH-1:0] lane_hi [WORDS];

   fifo_upsize_ctrl #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ctrl (
      .clk   (clk),
      .reset (reset),
      .wr    (wr),
      .rd    (rd),
      .wr_ok (wr_ok),
      .wr_ptr(wr_ptr),
      .rd_ptr(rd_ptr),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign wr_word    = wr_ptr[ADDR_WIDTH:1];
   assign opens_word = ~wr_ptr[0];

   // Lane choice: the byte that opens a word goes to the lane the byte order
   // reserves for the earlier byte; the closing byte takes the other lane.
   assign lo_we = wr_ok & (opens_word == first_byte_low(BYTE_ORDER));
   assign hi_we = wr_ok & (opens_word != first_byte_low(BYTE_ORDER));

   // Storage is deliberately not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (lo_we) lane_lo[wr_word] <= w_data;
      if (hi_we) lane_hi[wr_word] <= w_data;
   end

   assign r_data = {lane_hi[rd_ptr], lane_lo[rd_ptr]};

endmodule

// File: tb/tb_fifo_upsize.sv
// Directed bench for fifo_upsize (default parameters: 8-bit bytes, 16 bytes).
module tb_fifo_upsize;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [7:0]  w_data;
  logic        rd;
  logic [15:0] r_data;
  logic        full;
  logic        empty;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // expected words, oldest first
  logic [15:0] exp_q[$];

  // reference byte-level state
  int          mcount   = 0;
  logic        has_pend = 1'b0;
  logic [7:0]  pend     = 8'h00;

  fifo_upsize dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .w_data(w_data),
    .rd    (rd),
    .r_data(r_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, reference update, flag checks
  task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic rq);
    logic rok;
    logic wok;
    reset  = r;
    wr     = w;
    w_data = d;
    rd     = rq;
    if (r) begin
      exp_q.delete();
      has_pend = 1'b0;
      mcount   = 0;
    end else begin
      rok = rq && (mcount >= 2);
      wok = w && ((mcount < 16) || rok);
      if (wok) begin
        if (has_pend) begin
          exp_q.push_back({d, pend});
          has_pend = 1'b0;
        end else begin
          pend     = d;
          has_pend = 1'b1;
        end
      end
      mcount = mcount + (wok ? 1 : 0) - (rok ? 2 : 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    check("count", 32'(count), 32'(mcount));
    check("empty", 32'(empty), 32'(mcount < 2));
    check("full",  32'(full),  32'(mcount == 16));
  endtask

  task automatic write_byte(input logic [7:0] d);
    cycle(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic read_word();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // scoreboard monitor: a read is taken at the coming edge when rd=1, empty=0
  always @(negedge clk) begin
    if (!reset && rd && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_word: got %0h expected no word", r_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (r_data !== e) begin
          n_errors++;
          $display("FAIL sb_word: got %0h expected %0h", r_data, e);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = 8'h00;

    // reset, idle
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_full",  32'(full),  32'd0);
    check("idle_count", 32'(count), 32'd0);

    // two bytes form one word
    write_byte(8'h0f);
    check("half_empty", 32'(empty), 32'd1);
    check("half_count", 32'(count), 32'd1);
    write_byte(8'hff);
    check("pair_empty", 32'(empty), 32'd0);
    check("pair_rdata", 32'(r_data), 32'h0000_ff0f);
    read_word();

    // fill to capacity, overflow write ignored, drain
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    write_byte(8'hAA);
    check("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 8; i++) begin
      check("drain_rdata", 32'(r_data), {16'h0000, 8'(2*i+1), 8'(2*i)});
      read_word();
    end
    check("drain_empty", 32'(empty), 32'd1);
    read_word();  // read while empty: ignored

    // simultaneous read and write while full
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    check("rw_full_count", 32'(count), 32'd15);
    check("rw_full_full",  32'(full),  32'd0);
    for (int i = 0; i < 7; i++) read_word();
    check("rw_rem_count", 32'(count), 32'd1);
    write_byte(8'h66);
    check("rw_last_rdata", 32'(r_data), 32'h0000_6655);
    read_word();

    // one byte stored, rd+wr: only the write happens
    write_byte(8'h12);
    cycle(1'b0, 1'b1, 8'h34, 1'b1);
    check("one_rw_count", 32'(count), 32'd2);
    check("one_rw_rdata", 32'(r_data), 32'h0000_3412);
    read_word();

    // interleaved traffic across pointer wrap with a mid-stream reset
    for (int i = 0; i < 60; i++) begin
      if (i == 31) begin
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        check("mid_reset_count", 32'(count), 32'd0);
      end
      if ((i % 3) == 2) read_word();
      else              write_byte(8'(8'h80 + i));
    end
    for (int i = 0; i < 20; i++) begin
      if (mcount >= 2) read_word();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d words left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_upsize.md
FIFO_UPSIZE -- requirements
Module: fifo_upsize

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the write (byte) width; the read word width SHALL be 2*DATA_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the depth to 2**ADDR_WIDTH read words, i.e. 2**(ADDR_WIDTH+1) bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wr  input  1  SHALL be the write request, one byte per cycle.
REQ-006 w_data  input  DATA_WIDTH  SHALL be the byte written when wr is accepted.
REQ-007 rd  input  1  SHALL be the read request, one word per cycle.
REQ-008 r_data  output  2*DATA_WIDTH  SHALL present the oldest complete word (first-word-fall-through).
REQ-009 full  output  1  SHALL be high when the byte count equals 2**(ADDR_WIDTH+1).
REQ-010 empty  output  1  SHALL be high when fewer than 2 bytes are stored (no complete word).
REQ-011 count  output  ADDR_WIDTH+2  SHALL give the number of stored bytes, 0 to 2**(ADDR_WIDTH+1).

Function
REQ-012 Byte order SHALL be little-endian: the earlier byte of a pair occupies r_data[DATA_WIDTH-1:0]; the later byte occupies the upper half.
REQ-013 Write pointer SHALL be a byte pointer (ADDR_WIDTH+1 bits); read pointer SHALL be a word pointer (ADDR_WIDTH bits); both wrap modulo their range with no gap.
REQ-014 A write SHALL be accepted when wr=1 and (full=0, or rd=1 with empty=0 in the same cycle).
REQ-015 A read SHALL be accepted when rd=1 and empty=0; it pops exactly 2 bytes.
REQ-016 wr while full without an accepted read SHALL be ignored: no pointer, count or storage change.
REQ-017 rd while empty SHALL be ignored, including when exactly 1 byte is stored; that byte is retained.
REQ-018 Simultaneous accepted read and write SHALL change count by -1 in that cycle.
REQ-019 Simultaneous rd and wr with empty=1 SHALL perform only the write.
REQ-020 r_data SHALL be combinational from storage at the read pointer; it is undefined while empty=1.
REQ-021 A word completed by a write on edge N SHALL be visible on r_data, with empty=0, after edge N.
REQ-022 full, empty and count SHALL be registered or derived from registered state only; no combinational path from wr/rd.

Reset
REQ-023 With reset=1 at a rising edge, pointers and count SHALL clear to 0, empty=1, full=0, regardless of wr/rd.
REQ-024 Reset mid-operation SHALL discard all stored bytes, including a pending half word.
REQ-025 Storage contents need not be cleared by reset.

Structure
REQ-026 Package fifo_pkg SHALL hold the DATA_WIDTH/ADDR_WIDTH defaults and the byte-order constant shared with the downsizing FIFO.
REQ-027 Pointer, count and flag logic SHALL live in sub-module fifo_upsize_ctrl; the storage array and byte-lane write enables stay in fifo_upsize.

Verification
REQ-028 Reset, idle -> empty=1, full=0, count=0.
REQ-029 Write 8'h0f, then 8'hff -> after the first write empty=1 and count=1; after the second empty=0 and r_data=16'hff0f.
REQ-030 16 writes 8'h00..8'h0f (defaults) -> full=1, count=16; a 17th write of 8'hAA is ignored; 8 reads return 16'h0100, 16'h0302, ..., 16'h0f0e, then empty=1.
REQ-031 Full, rd=wr=1 with w_data=8'h55 -> count=15, full=0; 8'h55 is later read as the low byte of the final word.
REQ-032 1 byte stored (8'h12), rd=wr=1 with w_data=8'h34 -> read ignored, count=2, r_data=16'h3412.
REQ-033 Interleave 40 writes and 20 reads across pointer wrap, with reset asserted once mid-stream -> order preserved versus the scoreboard; after reset count=0 and pre-reset bytes are never returned.
